// File: rtl/defs.sv
// Shared command encodings for the temperature-monitor slave.
package tmon_defs_pkg;
    typedef enum logic [2:0] {
        RESET         = 3'd0,
        NOOP          = 3'd1,
        SET_FRQ       = 3'd2,
        SET_HIGH_TEMP = 3'd3
    } TMON_OP;
endpackage

// File: rtl/tmon_slave.sv
// Temperature monitor slave: periodic sampler with over-temperature alarm and a 2-state command port.
// Optional build macro TMON_HYST_EN lets the alarm self-clear below high_temp-HYST.
module tmon_slave
    import tmon_defs_pkg::*;
#(
    parameter logic [7:0] DEFAULT_FRQ  = 8'd10,
    parameter logic [7:0] DEFAULT_HIGH = 8'hFF,
    parameter logic [7:0] HYST         = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  TMON_OP     op,
    input  logic [7:0] opnd,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] temp_in,
    output logic [7:0] temp_out,
    output logic       sample_valid,
    output logic       alarm,
    output logic       op_ack,
    output logic       state_dbg
);

    // Handshake: a command transfers on a clock edge where valid && ready; upstream holds op/opnd until then.
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t     state, state_nxt;
    TMON_OP     op_q;
    logic [7:0] opnd_q;
    logic [7:0] frq;
    logic [7:0] high_temp;
    logic [7:0] cnt;
    logic       sample_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready      = (state == IDLE);
    assign state_dbg  = state;
    assign sample_hit = (frq != 8'd0) && (cnt == frq - 8'd1);

`ifdef TMON_HYST_EN
    logic [7:0] clr_thr;
    assign clr_thr = (high_temp >= HYST) ? (high_temp - HYST) : 8'd0;
`else
    logic unused_hyst;
    assign unused_hyst = ^HYST;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= NOOP;
            opnd_q <= 8'd0;
        end else if (ready && valid) begin
            op_q   <= op;
            opnd_q <= opnd;
        end
    end

    // Command writes come after the sample updates so a coincident sample sees the old settings.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frq          <= DEFAULT_FRQ;
            high_temp    <= DEFAULT_HIGH;
            cnt          <= 8'd0;
            temp_out     <= 8'd0;
            sample_valid <= 1'b0;
            alarm        <= 1'b0;
            op_ack       <= 1'b0;
        end else begin
            op_ack       <= 1'b0;
            sample_valid <= sample_hit;
            if (frq != 8'd0) cnt <= sample_hit ? 8'd0 : cnt + 8'd1;
            if (sample_hit) begin
                temp_out <= temp_in;
                if (temp_in > high_temp) alarm <= 1'b1;
`ifdef TMON_HYST_EN
                else if (temp_in < clr_thr) alarm <= 1'b0;
`endif
            end
            if (state == EXEC) begin
                op_ack <= 1'b1;
                case (op_q)
                    RESET: begin
                        frq       <= DEFAULT_FRQ;
                        high_temp <= DEFAULT_HIGH;
                        cnt       <= 8'd0;
                        alarm     <= 1'b0;
                        temp_out  <= 8'd0;
                    end
                    SET_FRQ: begin
                        frq <= opnd_q;
                        cnt <= 8'd0;
                    end
                    SET_HIGH_TEMP: high_temp <= opnd_q;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tmon_slave.sv
// Directed bench for tmon_slave: command handshake, sampling cadence, alarm and reset behaviour.
module tb_tmon_slave;
    import tmon_defs_pkg::*;

    logic       clk;
    logic       reset;
    TMON_OP     op;
    logic [7:0] opnd;
    logic       valid;
    logic       ready;
    logic [7:0] temp_in;
    logic [7:0] temp_out;
    logic       sample_valid;
    logic       alarm;
    logic       op_ack;
    logic       state_dbg;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    logic [7:0] exp_q[$];

    tmon_slave dut (
        .clk(clk), .reset(reset), .op(op), .opnd(opnd), .valid(valid), .ready(ready),
        .temp_in(temp_in), .temp_out(temp_out), .sample_valid(sample_valid),
        .alarm(alarm), .op_ack(op_ack), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges until the next sample_valid pulse (bounded); also reports any op_ack seen meanwhile.
    task automatic wait_sample(output int n, output bit acked);
        n = 0;
        acked = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            acked |= op_ack;
        end while (!sample_valid && n < 40);
    endtask

    task automatic check_sample(input string tag, input logic [7:0] t, input logic exp_alarm);
        int n;
        bit acked;
        logic [7:0] e;
        temp_in = t;
        exp_q.push_back(t);
        wait_sample(n, acked);
        chk({tag, "_seen"}, sample_valid, 1);
        e = exp_q.pop_front();
        chk({tag, "_temp"}, temp_out, e);
        chk({tag, "_alarm"}, alarm, exp_alarm);
    endtask

    task automatic send_cmd(input string tag, input TMON_OP c, input logic [7:0] d, input bit hold);
        int w = 0;
        @(negedge clk);
        op = c; opnd = d; valid = 1'b1;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_rdy"}, ready, 1);
        @(posedge clk); #1;
        if (!hold) valid = 1'b0;
        chk({tag, "_busy"}, ready, 0);
        chk({tag, "_ack_early"}, op_ack, 0);
        @(posedge clk); #1;
        valid = 1'b0;
        chk({tag, "_ack"}, op_ack, 1);
        chk({tag, "_idle"}, ready, 1);
        @(posedge clk); #1;
        chk({tag, "_ack_once"}, op_ack, 0);
    endtask

    initial begin
        int  n;
        int  hits;
        bit  acked;
        logic [7:0] e;

        reset = 1'b1; valid = 1'b0; op = NOOP; opnd = 8'd0; temp_in = 8'h20;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_state", state_dbg, 0);
        chk("rst_temp", temp_out, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_ack", op_ack, 0);

        // First sample after reset release lands on the tenth edge.
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(8'h20);
        wait_sample(n, acked);
        chk("first_latency", n, 10);
        e = exp_q.pop_front();
        chk("first_temp", temp_out, e);
        chk("first_alarm", alarm, 0);

        // Threshold is strict: equal does not alarm, one above does.
        send_cmd("set_high", SET_HIGH_TEMP, 8'h30, 1'b0);
        check_sample("eq_thr", 8'h30, 1'b0);
        check_sample("over_thr", 8'h31, 1'b1);

        send_cmd("unlisted", TMON_OP'(3'd7), 8'h00, 1'b0);
        chk("unlisted_alarm", alarm, 1);

`ifdef TMON_HYST_EN
        check_sample("hyst_drop", 8'h2D, 1'b0);
`else
        check_sample("hyst_drop", 8'h2D, 1'b1);
`endif

        send_cmd("rst_op", RESET, 8'h00, 1'b0);
        chk("rst_op_alarm", alarm, 0);
        chk("rst_op_temp", temp_out, 0);

        // With high_temp below HYST the clear threshold saturates at zero.
        send_cmd("set_high_low", SET_HIGH_TEMP, 8'h01, 1'b0);
        check_sample("sat_set", 8'h05, 1'b1);
        check_sample("sat_hold", 8'h00, 1'b1);
        send_cmd("rst_op2", RESET, 8'h00, 1'b0);
        chk("rst_op2_alarm", alarm, 0);

        send_cmd("frq0", SET_FRQ, 8'h00, 1'b0);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (sample_valid) hits++;
        end
        chk("frq0_no_samples", hits, 0);

        send_cmd("frq1", SET_FRQ, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            temp_in = 8'($urandom_range(0, 255));
            exp_q.push_back(temp_in);
            @(posedge clk); #1;
            chk("frq1_sv", sample_valid, 1);
            e = exp_q.pop_front();
            chk("frq1_temp", temp_out, e);
        end

        // valid held through EXEC must not produce a second acceptance.
        send_cmd("hold_valid", SET_FRQ, 8'd10, 1'b1);

        // Reset during EXEC discards the command: no ack and default sampling resumes.
        @(negedge clk);
        op = SET_FRQ; opnd = 8'd1; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("mid_busy", ready, 0);
        reset = 1'b1;
        #1;
        chk("mid_ready", ready, 1);
        chk("mid_ack", op_ack, 0);
        chk("mid_temp", temp_out, 0);
        chk("mid_sv", sample_valid, 0);
        chk("mid_alarm", alarm, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        temp_in = 8'h44;
        exp_q.push_back(8'h44);
        wait_sample(n, acked);
        chk("mid_no_ack", acked, 0);
        chk("mid_latency", n, 10);
        e = exp_q.pop_front();
        chk("mid_sample_temp", temp_out, e);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
